// File: rtl/btn_debounce_if.sv
// Signal bundle between a raw push-button and its conditioner:
// the raw level goes in, debounced press plus click/long_press pulses come out.
interface btn_debounce_if;
   logic usr_btn;
   logic click;
   logic press;
   logic long_press;

   modport master (output usr_btn, input click, press, long_press);
   modport slave  (input usr_btn, output click, press, long_press);
endinterface

// File: rtl/btn_debounce.sv
// Push-button conditioner: synchronize, debounce, and emit click / long_press pulses.
// BTN_SYNC_EN defined: 2-flop input synchronizer; undefined: single input register.
module btn_debounce #(
   parameter int CLK_FREQUENCY          = 100000000,
   parameter int BUTTON_INPUT_LEVEL     = 1,
   parameter int CLICK_OUTPUT_LEVEL     = 1,
   parameter int CLICK_DEBOUNCE_MS      = 10,
   parameter int PRESS_OUTPUT_LEVEL     = 1,
   parameter int LONG_PRESS_DURATION_MS = 1000
) (
   input  logic          clk,
   input  logic          resetn,
   btn_debounce_if.slave btn
);
   // state       | meaning
   // ST_RELEASED | debounced level released (db=0)
   // ST_PRESSED  | debounced level pressed, hold time not yet reached
   // ST_LONG     | debounced level pressed, long_press already issued

   localparam int D       = CLK_FREQUENCY / 1000 * CLICK_DEBOUNCE_MS;
   localparam int D_EFF   = (D > 1) ? D : 1;
   localparam int L       = CLK_FREQUENCY / 1000 * LONG_PRESS_DURATION_MS;
   localparam int DW      = ($clog2(D_EFF + 1) > 1) ? $clog2(D_EFF + 1) : 1;
   localparam int HW      = ($clog2(L + 1) > 1) ? $clog2(L + 1) : 1;
   localparam bit LONG_EN = (L > 0);

   localparam logic [DW-1:0] DEB_LAST = DW'(D_EFF - 1);
   localparam logic [HW-1:0] HOLD_MAX = HW'(L);
   localparam logic [HW-1:0] HOLD_HIT = HW'(LONG_EN ? L - 1 : 0);

   localparam logic BTN_ACT     = (BUTTON_INPUT_LEVEL != 0);
   localparam logic BTN_REL     = !BTN_ACT;
   localparam logic PRESS_ACT   = (PRESS_OUTPUT_LEVEL != 0);
   localparam logic PRESS_INACT = !PRESS_ACT;
   localparam logic CLICK_ACT   = (CLICK_OUTPUT_LEVEL != 0);
   localparam logic CLICK_INACT = !CLICK_ACT;

   typedef enum logic [1:0] {ST_RELEASED, ST_PRESSED, ST_LONG} state_t;

   state_t          state;
   logic [DW-1:0]   deb_cnt;
   logic [HW-1:0]   hold_cnt;
   logic            btn_sync;
   logic            press_q;
   logic            click_q;
   logic            long_q;
   logic            p;
   logic            db;
   logic            deb_done;
   logic            long_hit;

`ifdef BTN_SYNC_EN
   logic btn_meta;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         btn_meta <= BTN_REL;
         btn_sync <= BTN_REL;
      end else begin
         btn_meta <= btn.usr_btn;
         btn_sync <= btn_meta;
      end
   end
`else
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         btn_sync <= BTN_REL;
      end else begin
         btn_sync <= btn.usr_btn;
      end
   end
`endif

   assign p        = (btn_sync == BTN_ACT);
   assign db       = (state != ST_RELEASED);
   assign deb_done = (p != db) && (deb_cnt == DEB_LAST);
   assign long_hit = LONG_EN && (hold_cnt == HOLD_HIT);

   // A release in the same cycle the hold time would be reached counts as a click.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state    <= ST_RELEASED;
         deb_cnt  <= '0;
         hold_cnt <= '0;
         press_q  <= PRESS_INACT;
         click_q  <= CLICK_INACT;
         long_q   <= PRESS_INACT;
      end else begin
         click_q <= CLICK_INACT;
         long_q  <= PRESS_INACT;

         if ((p == db) || deb_done) begin
            deb_cnt <= '0;
         end else begin
            deb_cnt <= deb_cnt + 1'b1;
         end

         if (!db) begin
            hold_cnt <= '0;
         end else if (hold_cnt != HOLD_MAX) begin
            hold_cnt <= hold_cnt + 1'b1;
         end

         case (state)
            ST_RELEASED: begin
               if (deb_done) begin
                  state   <= ST_PRESSED;
                  press_q <= PRESS_ACT;
               end
            end
            ST_PRESSED: begin
               if (deb_done) begin
                  state   <= ST_RELEASED;
                  press_q <= PRESS_INACT;
                  click_q <= CLICK_ACT;
               end else if (long_hit) begin
                  state  <= ST_LONG;
                  long_q <= PRESS_ACT;
               end
            end
            ST_LONG: begin
               if (deb_done) begin
                  state   <= ST_RELEASED;
                  press_q <= PRESS_INACT;
               end
            end
            default: begin
               state   <= ST_RELEASED;
               press_q <= PRESS_INACT;
            end
         endcase
      end
   end

   assign btn.press      = press_q;
   assign btn.click      = click_q;
   assign btn.long_press = long_q;
endmodule

// File: tb/tb_btn_debounce.sv
// Self-checking bench for btn_debounce: event scoreboard fed by a stability-time model.
// Instance 0 is active-high with long press; instance 1 is active-low with long press disabled.
module tb_btn_debounce;
   localparam int CLK_HZ = 1000000;
   localparam int D_EFF  = 1000;
`ifdef BTN_SYNC_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   typedef struct packed {
      logic [1:0]  kind;
      int unsigned cyc;
   } ev_t;

   localparam logic [1:0] EV_RISE  = 2'd0;
   localparam logic [1:0] EV_FALL  = 2'd1;
   localparam logic [1:0] EV_CLICK = 2'd2;
   localparam logic [1:0] EV_LONG  = 2'd3;

   logic clk = 1'b0;
   logic resetn = 1'b1;
   logic raw [2];
   int   checks = 0;
   int   failures = 0;
   int   n_rise [2] = '{0, 0};
   int   n_click [2] = '{0, 0};
   int   n_long [2] = '{0, 0};
   int   pend [2] = '{0, 0};

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   for (genvar gi = 0; gi < 2; gi++) begin : g_inst
      localparam int   BIL  = (gi == 0) ? 1 : 0;
      localparam int   PRL  = (gi == 0) ? 1 : 0;
      localparam int   LMS  = (gi == 0) ? 5 : 0;
      localparam int   L    = CLK_HZ / 1000 * LMS;
      localparam logic BACT = (BIL != 0);
      localparam logic PACT = (PRL != 0);

      btn_debounce_if bif ();
      assign bif.usr_btn = raw[gi];

      btn_debounce #(
         .CLK_FREQUENCY          (CLK_HZ),
         .BUTTON_INPUT_LEVEL     (BIL),
         .CLICK_OUTPUT_LEVEL     (1),
         .CLICK_DEBOUNCE_MS      (1),
         .PRESS_OUTPUT_LEVEL     (PRL),
         .LONG_PRESS_DURATION_MS (LMS)
      ) dut (
         .clk    (clk),
         .resetn (resetn),
         .btn    (bif)
      );

      // Reference: the debounced level follows the button once the synchronized
      // input has disagreed with it for D_EFF cycles in a row.
      ev_t         expq [$];
      logic        dly [$];
      logic        db = 1'b0;
      logic        long_done = 1'b0;
      int unsigned ncyc = 0;
      int unsigned last_eq = 0;
      int unsigned rise_at = 0;

      always @(posedge clk) begin
         logic x;
         ncyc++;
         if (!resetn) begin
            dly.delete();
            for (int k = 0; k < LAT; k++) dly.push_back(1'b0);
            db = 1'b0;
            long_done = 1'b0;
            last_eq = ncyc;
         end else begin
            dly.push_back(raw[gi] === BACT);
            x = dly.pop_front();
            if (x == db) begin
               last_eq = ncyc;
            end else if (ncyc - last_eq >= D_EFF) begin
               if (!db) begin
                  db = 1'b1;
                  rise_at = ncyc;
                  expq.push_back(ev_t'{kind: EV_RISE, cyc: ncyc});
               end else begin
                  db = 1'b0;
                  expq.push_back(ev_t'{kind: EV_FALL, cyc: ncyc});
                  if (!long_done) expq.push_back(ev_t'{kind: EV_CLICK, cyc: ncyc});
                  long_done = 1'b0;
               end
               last_eq = ncyc;
            end
            if (L > 0 && db && !long_done && (ncyc - rise_at == L)) begin
               expq.push_back(ev_t'{kind: EV_LONG, cyc: ncyc});
               long_done = 1'b1;
            end
         end
      end

      task automatic take(input logic [1:0] k);
         ev_t e;
         checks++;
         if (expq.size() == 0) begin
            failures++;
            $display("FAIL inst%0d event actual kind=%0d cycle=%0d required none", gi, k, ncyc);
         end else begin
            e = expq.pop_front();
            if (e.kind != k || e.cyc != ncyc) begin
               failures++;
               $display("FAIL inst%0d event actual kind=%0d cycle=%0d required kind=%0d cycle=%0d",
                        gi, k, ncyc, e.kind, e.cyc);
            end
         end
         if (k == EV_RISE) n_rise[gi]++;
         if (k == EV_CLICK) n_click[gi]++;
         if (k == EV_LONG) n_long[gi]++;
      endtask

      logic prev_pr = 1'b0;

      always begin
         logic pr, ck, lp;
         @(posedge clk);
         #1;
         pr = (bif.press === PACT);
         ck = (bif.click === 1'b1);
         lp = (bif.long_press === PACT);
         if (!resetn) begin
            check($sformatf("reset_idle_inst%0d", gi), {29'd0, pr, ck, lp}, 0);
            prev_pr = 1'b0;
         end else begin
            if (pr != prev_pr) take(pr ? EV_RISE : EV_FALL);
            if (ck) take(EV_CLICK);
            if (lp) take(EV_LONG);
            prev_pr = pr;
         end
         pend[gi] = expq.size();
      end
   end

   task automatic hold(input int i, input bit pressed, input int n);
      raw[i] = (i == 0) ? pressed : !pressed;
      repeat (n) @(negedge clk);
   endtask

   task automatic rand_run(input int i, input int budget);
      int used = 0;
      bit lvl = 1'b0;
      int n;
      while (used < budget) begin
         case ($urandom_range(0, 3))
            0:       n = D_EFF - 1 + int'($urandom_range(0, 2));
            1:       n = int'($urandom_range(1, 40));
            2:       n = int'($urandom_range(1000, 4000));
            default: n = int'($urandom_range(5000, 7000));
         endcase
         lvl = !lvl;
         hold(i, lvl, n);
         used += n;
      end
      hold(i, 1'b0, D_EFF + LAT + 5);
   endtask

   initial begin
      int r, c, l;
      raw[0] = 1'b1;
      raw[1] = 1'b1;
      #2 resetn = 1'b0;
      repeat (5) @(negedge clk);
      check("rst_out_inst0", {29'd0, g_inst[0].bif.press, g_inst[0].bif.click, g_inst[0].bif.long_press}, 0);
      check("rst_out_inst1", {29'd0, g_inst[1].bif.press, g_inst[1].bif.click, g_inst[1].bif.long_press}, 5);

      // Button held across reset release: press after sync latency plus debounce.
      resetn = 1'b1;
      repeat (LAT + D_EFF - 1) @(negedge clk);
      check("press_before_latency", g_inst[0].bif.press, 0);
      @(negedge clk);
      check("press_at_latency", g_inst[0].bif.press, 1);
      hold(0, 1'b0, D_EFF + LAT + 5);

      r = n_rise[0];
      for (int k = 0; k < 5; k++) begin
         hold(0, 1'b1, D_EFF - 1);
         hold(0, 1'b0, 1);
      end
      check("bounce_rejected", n_rise[0] - r, 0);
      hold(0, 1'b1, D_EFF + LAT + 2);
      check("stable_press", g_inst[0].bif.press, 1);
      hold(0, 1'b0, D_EFF + LAT + 5);

      c = n_click[0];
      l = n_long[0];
      hold(0, 1'b1, 3000);
      hold(0, 1'b0, D_EFF + LAT + 5);
      check("short_click", n_click[0] - c, 1);
      check("short_no_long", n_long[0] - l, 0);

      c = n_click[0];
      l = n_long[0];
      hold(0, 1'b1, 8000);
      check("long_press_held", g_inst[0].bif.press, 1);
      hold(0, 1'b0, D_EFF + LAT + 5);
      check("long_pulse", n_long[0] - l, 1);
      check("long_no_click", n_click[0] - c, 0);

      c = n_click[0];
      l = n_long[0];
      hold(0, 1'b1, LAT + D_EFF + 4000);
      resetn = 1'b0;
      #1;
      check("reset_mid_press_async", g_inst[0].bif.press, 0);
      repeat (3) @(negedge clk);
      resetn = 1'b1;
      check("reset_mid_no_click", n_click[0] - c, 0);
      check("reset_mid_no_long", n_long[0] - l, 0);
      hold(0, 1'b1, LAT + D_EFF - 1);
      check("redebounce_wait", g_inst[0].bif.press, 0);
      hold(0, 1'b1, 2);
      check("redebounce_press", g_inst[0].bif.press, 1);
      hold(0, 1'b0, D_EFF + LAT + 5);

      c = n_click[1];
      l = n_long[1];
      hold(1, 1'b1, 10000);
      check("pol_press_active_low", g_inst[1].bif.press, 0);
      check("pol_long_idle", g_inst[1].bif.long_press, 1);
      hold(1, 1'b0, D_EFF + LAT + 5);
      check("pol_click", n_click[1] - c, 1);
      check("pol_no_long", n_long[1] - l, 0);
      check("pol_released", g_inst[1].bif.press, 1);

      fork
         rand_run(0, 20000);
         rand_run(1, 20000);
      join
      @(negedge clk);
      check("drained_inst0", pend[0], 0);
      check("drained_inst1", pend[1], 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
